vending_fsm_param: RTL

- Parametrised coin-accumulating vending controller; next generation of the fixed 5/10-unit vending FSM in the lab designs.
- Accepts five- and ten-coins, accumulates credit against a configurable PRICE, dispenses with a timed hold, and returns exact change.
- Supports a cancel/refund path, coin rejection while busy, and a wrapping sales counter.
- Drives LED/7-seg display logic downstream. Coin and cancel inputs come from debounced single-cycle pulse generators.

---
 rtl/vending_fsm_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vending_fsm_param.sv
// Parametrised coin-accumulating vending controller.
// Accepts five- and ten-coins against PRICE, holds done/change outputs for
// HOLD_CYCLES cycles after a dispense or refund, and counts completed sales.
module vending_fsm_param #(
  parameter int unsigned PRICE       = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned SALES_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                five,
  input  logic                ten,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                done,
  output logic                change,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                reject,
  output logic                busy,
  output logic [SALES_W-1:0]  sales
);

  // Hold counter only needs to reach HOLD_CYCLES-1; one extra bit keeps coin sums from overflowing.
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned SUM_W  = CREDIT_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                done_q, done_d;
  logic                change_q, change_d;
  logic [CREDIT_W-1:0] amt_q, amt_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;
  logic [SALES_W-1:0]  sales_q, sales_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                coin_any;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    new_credit;

  // Coin decode: five takes priority when both pulses coincide.
  always_comb begin
    coin_any   = five | ten;
    coin_val   = five ? SUM_W'(1) : (ten ? SUM_W'(2) : SUM_W'(0));
    new_credit = SUM_W'(credit_q) + coin_val;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    done_d   = done_q;
    change_d = change_q;
    amt_d    = amt_q;
    reject_d = 1'b0;
    sales_d  = sales_q;
    hold_d   = hold_q;

    case (state_q)
      IDLE, COLLECT: begin
        done_d   = 1'b0;
        change_d = 1'b0;
        amt_d    = '0;
        hold_d   = '0;
        if (cancel && (state_q == COLLECT)) begin
          // Cancel wins over any coin in the same cycle; refund the pre-coin credit.
          state_d  = REFUND;
          change_d = 1'b1;
          amt_d    = credit_q;
          credit_d = '0;
          hold_d   = HOLD_W'(HOLD_CYCLES - 1);
          reject_d = coin_any;
        end else if (coin_any) begin
          reject_d = five & ten;
          if (new_credit >= SUM_W'(PRICE)) begin
            state_d  = DISPENSE;
            done_d   = 1'b1;
            amt_d    = CREDIT_W'(new_credit - SUM_W'(PRICE));
            change_d = (new_credit != SUM_W'(PRICE));
            credit_d = '0;
            hold_d   = HOLD_W'(HOLD_CYCLES - 1);
            sales_d  = sales_q + SALES_W'(1);
          end else begin
            state_d  = COLLECT;
            credit_d = CREDIT_W'(new_credit);
          end
        end
      end

      DISPENSE, REFUND: begin
        // Coins are refused while busy; cancel is ignored.
        reject_d = coin_any;
        credit_d = '0;
        if (hold_q == '0) begin
          state_d  = IDLE;
          done_d   = 1'b0;
          change_d = 1'b0;
          amt_d    = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
        done_d   = 1'b0;
        change_d = 1'b0;
        amt_d    = '0;
        hold_d   = '0;
      end
    endcase

    busy_d = (state_d == DISPENSE) || (state_d == REFUND);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      done_q   <= 1'b0;
      change_q <= 1'b0;
      amt_q    <= '0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      sales_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      done_q   <= done_d;
      change_q <= change_d;
      amt_q    <= amt_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
      sales_q  <= sales_d;
      hold_q   <= hold_d;
    end
  end

  assign credit     = credit_q;
  assign done       = done_q;
  assign change     = change_q;
  assign change_amt = amt_q;
  assign reject     = reject_q;
  assign busy       = busy_q;
  assign sales      = sales_q;

endmodule
